// File: rtl/complement_seq.sv
// complement_seq: multi-cycle, chunk-serial complement engine.
//
// Processes a WIDTH-bit operand CHUNK bits per clock, LSB chunk first,
// rippling the carry from one chunk to the next. Supported modes:
//   00 pass-through, 01 ones' complement, 10 two's complement, 11 absolute value.
// The result takes N = WIDTH/CHUNK cycles. WIDTH must be a multiple of CHUNK.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     request; accepted only while busy is low (IDLE or DONE)
//   mode      operation select, sampled only on the accepting edge
//   in        operand, sampled only on the accepting edge
//   busy      high while chunks are being processed
//   done      one-cycle pulse when out/overflow are valid
//   out       result, held until the next accepted start
//   overflow  result not representable (most-negative operand), held with out

module complement_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] operand;
    logic [1:0]       opMode;
    logic             invert;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic             acceptCarry;
    logic             acceptInvert;
    logic [CHUNK-1:0] opChunk;
    logic [CHUNK:0]   chunkSum;
    logic             ovfNext;

    // Absolute value behaves as two's complement when the operand is
    // negative and as pass-through otherwise, so both the invert mask and
    // the initial carry come from the operand sign bit.
    always_comb begin
        acceptCarry  = 1'b0;
        acceptInvert = 1'b0;
        case (mode)
            2'b01: begin
                acceptInvert = 1'b1;
            end
            2'b10: begin
                acceptInvert = 1'b1;
                acceptCarry  = 1'b1;
            end
            2'b11: begin
                acceptInvert = in[WIDTH-1];
                acceptCarry  = in[WIDTH-1];
            end
            default: begin
                acceptInvert = 1'b0;
                acceptCarry  = 1'b0;
            end
        endcase
    end

    // One chunk of the ripple: conditionally invert, then add the carry.
    // The extra top bit of chunkSum is the carry into the next chunk.
    always_comb begin
        opChunk  = operand[idx*CHUNK +: CHUNK];
        chunkSum = {1'b0, opChunk ^ {CHUNK{invert}}} + {{CHUNK{1'b0}}, carry};
    end

    // Overflow is decided on the final chunk, whose top bit is the result MSB.
    // Negating or taking abs of the most-negative value yields itself, the
    // only case where a "negative" sign survives the operation.
    always_comb begin
        ovfNext = 1'b0;
        case (opMode)
            2'b10:   ovfNext = operand[WIDTH-1] & chunkSum[CHUNK-1];
            2'b11:   ovfNext = chunkSum[CHUNK-1];
            default: ovfNext = 1'b0;
        endcase
    end

    // Control FSM and datapath registers. out is not cleared on accept: it
    // is overwritten chunk by chunk and is only meaningful when done pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            operand  <= '0;
            opMode   <= 2'b00;
            invert   <= 1'b0;
            carry    <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        operand <= in;
                        opMode  <= mode;
                        invert  <= acceptInvert;
                        carry   <= acceptCarry;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    out[idx*CHUNK +: CHUNK] <= chunkSum[CHUNK-1:0];
                    carry                   <= chunkSum[CHUNK];
                    if (idx == LAST) begin
                        overflow <= ovfNext;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
